fma_pack: RTL and testbench

FMA_PACK -- requirements
Module: fma_pack

---
 rtl/fma_pkg.sv | 40 ++++
 rtl/fma_lzc50.sv | 19 +
 rtl/fma_pack.sv | 187 ++++++++++++++++++
 tb/tb_fma_pack.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/fma_pkg.sv
// Shared constants and inter-stage records for the fma_pack normalize/round/pack pipeline.
package fma_pkg;

  localparam int SIG_W_DEF = 50;
  localparam int EXP_W_DEF = 10;
  localparam int E_W       = 12;
  localparam int BIAS      = 127;
  localparam int EXP_MAX   = 2 * BIAS + 1;

  localparam logic [31:0] QNAN = 32'h7FC00000;
  localparam logic [31:0] PINF = 32'h7F800000;

  localparam int FLAG_OVF = 2;
  localparam int FLAG_UNF = 1;
  localparam int FLAG_INX = 0;

  // Normalized operand: leading one at sig[46], e is the biased exponent of that one.
  typedef struct packed {
    logic                  sign;
    logic                  nan;
    logic                  inf;
    logic                  zero;
    logic                  tiny;
    logic                  sticky;
    logic signed [E_W-1:0] e;
    logic [46:0]           sig;
  } s1_t;

  typedef struct packed {
    logic                  sign;
    logic                  nan;
    logic                  inf;
    logic                  zero;
    logic                  tiny;
    logic                  inexact;
    logic signed [E_W-1:0] e;
    logic [22:0]           frac;
  } s2_t;

endpackage

// File: rtl/fma_lzc50.sv
// Combinational leading-zero count of a 50-bit vector; zero flags an all-zero input.
module fma_lzc50 (
  input  logic [49:0] in_bits,
  output logic [5:0]  lzc,
  output logic        zero
);

  // Scan upward so the highest set bit is the last one to write the count.
  always_comb begin
    lzc  = 6'd50;
    zero = ~|in_bits;
    for (int i = 0; i < 50; i++) begin
      if (in_bits[i]) begin
        lzc = 6'(49 - i);
      end
    end
  end

endmodule

// File: rtl/fma_pack.sv
// fma_pack: 3-stage normalize / round-to-nearest-even / pack into an IEEE-754 single.
// Define FMA_PACK_SUBNORMAL_EN to emit subnormals instead of flushing tiny results to zero.
module fma_pack
  import fma_pkg::*;
#(
  parameter int SIG_W = SIG_W_DEF,
  parameter int EXP_W = EXP_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             sign_in,
  input  logic [EXP_W-1:0] exp_in,
  input  logic [SIG_W-1:0] sig_in,
  input  logic             sticky_in,
  input  logic             nan_in,
  input  logic             inf_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      result_out,
  output logic [2:0]       flags_out
);

  logic        s1_valid_q, s1_valid_d, s2_valid_q, s2_valid_d, out_valid_q, out_valid_d;
  s1_t         s1_q, s1_d, s1_res;
  s2_t         s2_q, s2_d, s2_res;
  logic [31:0] result_q, result_d, result_res;
  logic [2:0]  flags_q, flags_d, flags_res;
  logic        s3_ready, s2_ready, s1_ready;

  logic [5:0]            lzc;
  logic                  sig_zero;
  logic [49:0]           sig_shl;
  logic signed [E_W-1:0] e_in, e_norm;
  logic                  lsb, guard, st, rnd_inc;
  logic [24:0]           rnd_sum;
`ifdef FMA_PACK_SUBNORMAL_EN
  logic [4:0]            sub_sh;
  logic [72:0]           sub_wide;
`endif

  fma_lzc50 u_lzc (
    .in_bits (sig_in),
    .lzc     (lzc),
    .zero    (sig_zero)
  );

  assign s3_ready = !out_valid_q || out_ready;
  assign s2_ready = !s2_valid_q || s3_ready;
  assign s1_ready = !s1_valid_q || s2_ready;
  assign in_ready   = s1_ready;
  assign out_valid  = out_valid_q;
  assign result_out = result_q;
  assign flags_out  = flags_q;

  // S1: put the leading one at bit 46; bits pushed out of a right shift feed sticky.
  always_comb begin
    sig_shl = sig_in << lzc;
    e_in    = {{(E_W - EXP_W){exp_in[EXP_W-1]}}, exp_in};
    e_norm  = e_in + 12'sd3 - $signed({6'b0, lzc});
    s1_res        = '0;
    s1_res.sign   = sign_in;
    s1_res.nan    = nan_in;
    s1_res.inf    = inf_in;
    s1_res.zero   = sig_zero;
    s1_res.tiny   = (e_norm <= 12'sd0);
    s1_res.e      = e_norm;
    s1_res.sig    = sig_shl[49:3];
    s1_res.sticky = sticky_in | (|sig_shl[2:0]);
`ifdef FMA_PACK_SUBNORMAL_EN
    sub_sh   = 5'd0;
    sub_wide = '0;
    if (e_norm <= 12'sd0) begin
      sub_sh        = (e_norm < -12'sd25) ? 5'd26 : 5'(12'sd1 - e_norm);
      sub_wide      = {sig_shl[49:3], 26'b0} >> sub_sh;
      s1_res.sig    = sub_wide[72:26];
      s1_res.sticky = s1_res.sticky | (|sub_wide[25:0]);
    end
`endif
  end

  // S2: round to nearest even; a carry out of the 24-bit significand renormalizes.
  always_comb begin
    lsb     = s1_q.sig[23];
    guard   = s1_q.sig[22];
    st      = (|s1_q.sig[21:0]) | s1_q.sticky;
    rnd_inc = guard & (st | lsb);
    rnd_sum = {1'b0, s1_q.sig[46:23]} + {24'b0, rnd_inc};
    s2_res         = '0;
    s2_res.sign    = s1_q.sign;
    s2_res.nan     = s1_q.nan;
    s2_res.inf     = s1_q.inf;
    s2_res.zero    = s1_q.zero;
    s2_res.tiny    = s1_q.tiny;
    s2_res.inexact = guard | st;
    if (rnd_sum[24]) begin
      s2_res.frac = rnd_sum[23:1];
      s2_res.e    = s1_q.e + 12'sd1;
    end else begin
      s2_res.frac = rnd_sum[22:0];
      s2_res.e    = s1_q.e;
    end
`ifdef FMA_PACK_SUBNORMAL_EN
    if (s1_q.tiny) begin
      s2_res.e = rnd_sum[23] ? 12'sd1 : 12'sd0;
    end
`endif
  end

  // S3: specials first, then tiny handling, overflow, and the ordinary pack.
  always_comb begin
    result_res = '0;
    flags_res  = '0;
    if (s2_q.nan) begin
      result_res = QNAN;
    end else if (s2_q.inf) begin
      result_res = {s2_q.sign, PINF[30:0]};
    end else if (s2_q.zero) begin
      result_res = {s2_q.sign, 31'b0};
    end else if (s2_q.tiny) begin
`ifdef FMA_PACK_SUBNORMAL_EN
      result_res          = {s2_q.sign, s2_q.e[7:0], s2_q.frac};
      flags_res[FLAG_UNF] = s2_q.inexact;
      flags_res[FLAG_INX] = s2_q.inexact;
`else
      result_res          = {s2_q.sign, 31'b0};
      flags_res[FLAG_UNF] = 1'b1;
      flags_res[FLAG_INX] = 1'b1;
`endif
    end else if (s2_q.e >= $signed(12'(EXP_MAX))) begin
      result_res          = {s2_q.sign, PINF[30:0]};
      flags_res[FLAG_OVF] = 1'b1;
      flags_res[FLAG_INX] = 1'b1;
    end else begin
      result_res          = {s2_q.sign, s2_q.e[7:0], s2_q.frac};
      flags_res[FLAG_INX] = s2_q.inexact;
    end
  end

  // Each stage loads only when the stage after it can take its current contents.
  always_comb begin
    s1_valid_d  = s1_valid_q;
    s1_d        = s1_q;
    s2_valid_d  = s2_valid_q;
    s2_d        = s2_q;
    out_valid_d = out_valid_q;
    result_d    = result_q;
    flags_d     = flags_q;
    if (s1_ready) begin
      s1_valid_d = in_valid;
      s1_d       = s1_res;
    end
    if (s2_ready) begin
      s2_valid_d = s1_valid_q;
      s2_d       = s2_res;
    end
    if (s3_ready) begin
      out_valid_d = s2_valid_q;
      if (s2_valid_q) begin
        result_d = result_res;
        flags_d  = flags_res;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q  <= 1'b0;
      s2_valid_q  <= 1'b0;
      out_valid_q <= 1'b0;
      s1_q        <= '0;
      s2_q        <= '0;
      result_q    <= '0;
      flags_q     <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s2_valid_q  <= s2_valid_d;
      out_valid_q <= out_valid_d;
      s1_q        <= s1_d;
      s2_q        <= s2_d;
      result_q    <= result_d;
      flags_q     <= flags_d;
    end
  end

endmodule

// File: tb/tb_fma_pack.sv
// Directed-vector bench for fma_pack: single operands, backpressure streaming and mid-flight reset.
// Expected subnormal results follow FMA_PACK_SUBNORMAL_EN when it is defined.
module tb_fma_pack;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic        sign_in;
  logic [9:0]  exp_in;
  logic [49:0] sig_in;
  logic        sticky_in;
  logic        nan_in;
  logic        inf_in;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result_out;
  logic [2:0]  flags_out;

  int errorCount = 0;
  int checkCount = 0;

  localparam logic [49:0] ONE46 = 50'd1 << 46;

  fma_pack dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .sign_in    (sign_in),
    .exp_in     (exp_in),
    .sig_in     (sig_in),
    .sticky_in  (sticky_in),
    .nan_in     (nan_in),
    .inf_in     (inf_in),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .result_out (result_out),
    .flags_out  (flags_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checkCount++;
    if (got !== exp) begin
      errorCount++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic driveOperand(input logic s, input logic [9:0] e, input logic [49:0] sg,
                              input logic st, input logic nn, input logic nf);
    sign_in   = s;
    exp_in    = e;
    sig_in    = sg;
    sticky_in = st;
    nan_in    = nn;
    inf_in    = nf;
  endtask

  // One operand through an otherwise empty pipeline; latency counts the accepting edge as 1.
  task automatic applyStimulus(input string tag, input logic s, input logic [9:0] e,
                               input logic [49:0] sg, input logic st, input logic nn,
                               input logic nf, input logic [31:0] expRes, input logic [2:0] expFlags);
    int lat;
    @(negedge clk);
    driveOperand(s, e, sg, st, nn, nf);
    in_valid  = 1'b1;
    out_ready = 1'b1;
    #1;
    checkOutput({tag, ".ready"}, 32'(in_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 10) begin
      @(posedge clk);
      @(negedge clk);
      lat++;
    end
    checkOutput({tag, ".latency"}, 32'(lat), 32'd3);
    checkOutput({tag, ".result"}, result_out, expRes);
    checkOutput({tag, ".flags"}, {29'b0, flags_out}, {29'b0, expFlags});
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int idx;
    int got;
    int stale;
    logic wasReady;

    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    driveOperand(1'b0, 10'd0, 50'd0, 1'b0, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("reset.outValid", 32'(out_valid), 32'd0);
    checkOutput("reset.result", result_out, 32'h0);
    checkOutput("reset.flags", {29'b0, flags_out}, 32'h0);
    checkOutput("reset.inReady", 32'(in_ready), 32'd1);
    rst = 1'b0;

    applyStimulus("one", 1'b0, 10'd127, ONE46, 1'b0, 1'b0, 1'b0, 32'h3F800000, 3'b000);
    applyStimulus("tieEven", 1'b0, 10'd127, ONE46 | (50'd1 << 22), 1'b0, 1'b0, 1'b0,
                  32'h3F800000, 3'b001);
    applyStimulus("tieOdd", 1'b0, 10'd127, ONE46 | (50'd1 << 23) | (50'd1 << 22), 1'b0, 1'b0, 1'b0,
                  32'h3F800002, 3'b001);
    applyStimulus("stickyIn", 1'b0, 10'd127, ONE46 | (50'd1 << 22), 1'b1, 1'b0, 1'b0,
                  32'h3F800001, 3'b001);
    applyStimulus("rshSticky", 1'b0, 10'd124, (50'd1 << 49) | 50'd1, 1'b0, 1'b0, 1'b0,
                  32'h3F800000, 3'b001);
    applyStimulus("carry47", 1'b0, 10'd127, (50'd1 << 47) - (50'd1 << 22), 1'b0, 1'b0, 1'b0,
                  32'h40000000, 3'b001);
    applyStimulus("sixPt0", 1'b0, 10'd127, 50'd3 << 47, 1'b0, 1'b0, 1'b0, 32'h40C00000, 3'b000);
    applyStimulus("fivePt0", 1'b0, 10'd173, 50'd5, 1'b0, 1'b0, 1'b0, 32'h40A00000, 3'b000);
    applyStimulus("maxNorm", 1'b0, 10'd254, ONE46, 1'b0, 1'b0, 1'b0, 32'h7F000000, 3'b000);
    applyStimulus("minNorm", 1'b0, 10'd1, ONE46, 1'b0, 1'b0, 1'b0, 32'h00800000, 3'b000);
    applyStimulus("ovf", 1'b0, 10'd253, 50'd1 << 49, 1'b0, 1'b0, 1'b0, 32'h7F800000, 3'b101);
    applyStimulus("ovfRound", 1'b1, 10'd254, (50'd1 << 47) - (50'd1 << 22), 1'b0, 1'b0, 1'b0,
                  32'hFF800000, 3'b101);
    applyStimulus("negZero", 1'b1, 10'd127, 50'd0, 1'b0, 1'b0, 1'b0, 32'h80000000, 3'b000);
    applyStimulus("nan", 1'b1, 10'd127, ONE46, 1'b0, 1'b1, 1'b1, 32'h7FC00000, 3'b000);
    applyStimulus("negInf", 1'b1, 10'd127, ONE46, 1'b0, 1'b0, 1'b1, 32'hFF800000, 3'b000);
`ifdef FMA_PACK_SUBNORMAL_EN
    applyStimulus("tinyE0", 1'b0, 10'd0, ONE46, 1'b0, 1'b0, 1'b0, 32'h00400000, 3'b000);
    applyStimulus("tinyNeg", 1'b0, 10'h3FB, 50'd1 << 49, 1'b0, 1'b0, 1'b0, 32'h00100000, 3'b000);
`else
    applyStimulus("tinyE0", 1'b0, 10'd0, ONE46, 1'b0, 1'b0, 1'b0, 32'h00000000, 3'b011);
    applyStimulus("tinyNeg", 1'b1, 10'h3FB, 50'd1 << 49, 1'b0, 1'b0, 1'b0, 32'h80000000, 3'b011);
`endif

    // Fill the pipeline against a stalled consumer, then drain it in order.
    @(negedge clk);
    out_ready = 1'b0;
    idx = 0;
    for (int c = 0; c < 6; c++) begin
      in_valid = (idx < 5);
      driveOperand(1'b0, 10'(127 + idx), ONE46, 1'b0, 1'b0, 1'b0);
      #1;
      wasReady = in_ready;
      @(posedge clk);
      @(negedge clk);
      if (in_valid && wasReady) idx++;
    end
    checkOutput("fill.accepts", 32'(idx), 32'd3);
    checkOutput("fill.inReady", 32'(in_ready), 32'd0);
    checkOutput("fill.outValid", 32'(out_valid), 32'd1);
    checkOutput("fill.hold", result_out, 32'h3F800000);

    out_ready = 1'b1;
    got = 0;
    for (int c = 0; c < 40 && got < 5; c++) begin
      in_valid = (idx < 5);
      driveOperand(1'b0, 10'(127 + idx), ONE46, 1'b0, 1'b0, 1'b0);
      #1;
      wasReady = in_ready;
      if (out_valid) begin
        checkOutput($sformatf("stream%0d", got), result_out, {1'b0, 8'(127 + got), 23'b0});
        got++;
      end
      @(posedge clk);
      @(negedge clk);
      if (in_valid && wasReady) idx++;
    end
    in_valid = 1'b0;
    checkOutput("stream.count", 32'(got), 32'd5);

    // Two operands in flight plus a third offered on the reset edge: none may emerge.
    @(negedge clk);
    driveOperand(1'b0, 10'd127, ONE46, 1'b0, 1'b0, 1'b0);
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    driveOperand(1'b0, 10'd128, ONE46, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    @(negedge clk);
    driveOperand(1'b0, 10'd129, ONE46, 1'b0, 1'b0, 1'b0);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    in_valid = 1'b0;
    checkOutput("rst.outValid", 32'(out_valid), 32'd0);
    checkOutput("rst.result", result_out, 32'h0);
    checkOutput("rst.inReady", 32'(in_ready), 32'd1);
    stale = 0;
    repeat (6) begin
      @(posedge clk);
      @(negedge clk);
      if (out_valid) stale++;
    end
    checkOutput("rst.stale", 32'(stale), 32'd0);
    applyStimulus("postRst", 1'b1, 10'd128, ONE46, 1'b0, 1'b0, 1'b0, 32'hC0000000, 3'b000);

    $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
    $finish;
  end

endmodule
